// File: rtl/reg_file_scoreboard.sv
// Register file with write-to-read bypass and per-register pending-write counters.
// Decode reads two operands; an operand with an outstanding write raises stall.
module reg_file_scoreboard_rdport #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic [2**ADDR_W-1:0][WIDTH-1:0]  mem_i,
    input  logic [2**ADDR_W-1:0][PEND_W-1:0] pend_i,
    input  logic                             wr_act_i,
    input  logic [ADDR_W-1:0]                wr_addr_i,
    input  logic [WIDTH-1:0]                 wr_data_i,
    input  logic [ADDR_W-1:0]                rd_addr_i,
    input  logic                             use_i,
    output logic [WIDTH-1:0]                 rd_data_o,
    output logic                             busy_o,
    output logic                             stall_o
);
    logic hit;

    assign hit       = wr_act_i && (wr_addr_i == rd_addr_i);
    assign rd_data_o = (rd_addr_i == '0) ? '0 : (hit ? wr_data_i : mem_i[rd_addr_i]);
    // The last outstanding write retiring now is already visible via the bypass.
    assign busy_o    = (pend_i[rd_addr_i] != '0) && !(hit && pend_i[rd_addr_i] == PEND_W'(1));
    assign stall_o   = use_i && busy_o;
endmodule

module reg_file_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              use_a,
    input  logic              use_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NUM_LANES = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [DEPTH-1:0][WIDTH-1:0]  mem_q;
    logic [DEPTH-1:0][PEND_W-1:0] pend_q, pend_d;
    logic [DEPTH-1:0]             ovf, unf;
    logic                         err_q, err_d;
    logic                         wr_act, rsv_act;

    logic [NUM_LANES-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_LANES-1:0]             rd_use, rd_busy, rd_stall;
    logic [NUM_LANES-1:0][WIDTH-1:0]  rd_data;

    // Gating with rst_n keeps the bypass dark while reset is held.
    assign wr_act  = rst_n && wr_en  && (wr_addr  != '0);
    assign rsv_act = rst_n && rsv_en && (rsv_addr != '0);

    always_comb begin
        pend_d = pend_q;
        ovf    = '0;
        unf    = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (rsv_act && rsv_addr == ADDR_W'(r) && !(wr_act && wr_addr == ADDR_W'(r))) begin
                if (pend_q[r] == PEND_MAX) ovf[r] = 1'b1;
                else                       pend_d[r] = pend_q[r] + 1'b1;
            end else if (wr_act && wr_addr == ADDR_W'(r) && !(rsv_act && rsv_addr == ADDR_W'(r))) begin
                if (pend_q[r] == '0) unf[r] = 1'b1;
                else                 pend_d[r] = pend_q[r] - 1'b1;
            end
        end
        err_d = err_q | (|ovf) | (|unf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            if (wr_act) mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_addr = {rd_addr_b, rd_addr_a};
    assign rd_use  = {use_b, use_a};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_rd
        reg_file_scoreboard_rdport #(
            .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PEND_W(PEND_W)
        ) u_rdport (
            .mem_i     (mem_q),
            .pend_i    (pend_q),
            .wr_act_i  (wr_act),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_addr_i (rd_addr[l]),
            .use_i     (rd_use[l]),
            .rd_data_o (rd_data[l]),
            .busy_o    (rd_busy[l]),
            .stall_o   (rd_stall[l])
        );
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
    assign busy_a    = rd_busy[0];
    assign busy_b    = rd_busy[1];
    assign stall     = |rd_stall;
    assign err       = err_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: reset, r0, bypass, stall, WAW, error and async reset.
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr_a, rd_addr_b, rsv_addr, wr_addr;
    logic        use_a, use_b, rsv_en, wr_en;
    logic [31:0] rd_data_a, rd_data_b, wr_data;
    logic        busy_a, busy_b, stall, err;

    int n_chk  = 0;
    int n_pass = 0;

    reg_file_scoreboard #(.WIDTH(32), .ADDR_W(5), .PEND_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .use_a(use_a), .use_b(use_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b), .stall(stall),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsv_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_en = 1'b1; rsv_addr = a; wr_en = 1'b0;
        tick();
        idle();
    endtask

    initial begin
        rst_n = 1'b0; use_a = 1'b0; use_b = 1'b0;
        rd_addr_a = 5'd3; rd_addr_b = 5'd0; rsv_en = 1'b0; rsv_addr = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        tick(); tick();
        chk("rst_bypass_gated", rd_data_a, 32'h0);
        chk("rst_busy", {30'd0, busy_a, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; idle();
        tick();
        chk("rst_data3", rd_data_a, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);

        // register 0
        rd_addr_a = 5'd0; use_a = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("r0_bypass", rd_data_a, 32'h0);
        chk("r0_busy_now", {31'd0, busy_a}, 32'h0);
        tick(); idle();
        chk("r0_read", rd_data_a, 32'h0);
        chk("r0_busy_next", {30'd0, busy_a, stall}, 32'h0);
        chk("r0_err", {31'd0, err}, 32'h0);
        use_a = 1'b0;

        // bypass on address 5 (reservations keep the scoreboard balanced)
        rsv(5'd5);
        rsv_en = 1'b1; rsv_addr = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
        tick(); idle();
        rd_addr_a = 5'd5; #1;
        chk("byp_stored", rd_data_a, 32'h11111111);
        chk("byp_busy_pend", {31'd0, busy_a}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5; #1;
        chk("byp_same_cycle", rd_data_a, 32'hA5A5A5A5);
        chk("byp_last_not_busy", {31'd0, busy_a}, 32'h0);
        tick(); idle(); #1;
        chk("byp_next_cycle", rd_data_a, 32'hA5A5A5A5);
        chk("byp_err", {31'd0, err}, 32'h0);

        // scoreboard stall on address 7
        rd_addr_b = 5'd7; use_b = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd7; #1;
        chk("stall_rsv_same_cycle", {30'd0, busy_b, stall}, 32'h0);
        tick(); idle(); #1;
        chk("stall_busy_b", {30'd0, busy_b, stall}, 32'h3);
        use_b = 1'b0; #1;
        chk("stall_use_b_0", {31'd0, stall}, 32'h0);
        use_b = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D; #1;
        chk("stall_wb_clear", {30'd0, busy_b, stall}, 32'h0);
        chk("stall_wb_data", rd_data_b, 32'hCAFEF00D);
        tick(); idle(); use_b = 1'b0;

        // simultaneous reserve and write on address 4
        rsv(5'd4);
        rd_addr_a = 5'd4;
        rsv_en = 1'b1; rsv_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44444444;
        tick(); idle(); #1;
        chk("simul_busy", {31'd0, busy_a}, 32'h1);
        chk("simul_err", {31'd0, err}, 32'h0);
        chk("simul_data", rd_data_a, 32'h44444444);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44444445;
        tick(); idle(); #1;
        chk("simul_retired", {31'd0, busy_a}, 32'h0);

        // WAW: three reservations saturate, the fourth overflows
        rd_addr_a = 5'd9;
        rsv(5'd9); rsv(5'd9); rsv(5'd9);
        chk("waw_busy", {31'd0, busy_a}, 32'h1);
        chk("waw_err_before", {31'd0, err}, 32'h0);
        rsv(5'd9);
        chk("waw_overflow_err", {31'd0, err}, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'(i); #1;
            chk($sformatf("waw_wb%0d_busy", i), {31'd0, busy_a}, (i == 3) ? 32'h0 : 32'h1);
            tick(); idle();
        end
        chk("waw_final_busy", {31'd0, busy_a}, 32'h0);
        chk("waw_final_data", rd_data_a, 32'h3);

        // asynchronous reset mid-operation on address 2
        rd_addr_a = 5'd2; use_a = 1'b1;
        rsv(5'd2); rsv(5'd2); rsv(5'd2);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22222222;
        tick(); idle(); #1;
        chk("mid_pre_busy", {30'd0, busy_a, stall}, 32'h3);
        chk("mid_pre_data", rd_data_a, 32'h22222222);
        chk("mid_pre_err", {31'd0, err}, 32'h1);
        rst_n = 1'b0; #1;
        chk("mid_rst_busy", {30'd0, busy_a, stall}, 32'h0);
        chk("mid_rst_err", {31'd0, err}, 32'h0);
        chk("mid_rst_data", rd_data_a, 32'h0);
        rst_n = 1'b1;
        tick(); #1;
        chk("mid_after_data", rd_data_a, 32'h0);
        chk("mid_after_stall", {31'd0, stall}, 32'h0);
        use_a = 1'b0;

        // underflow: write to address 6 with nothing pending
        rd_addr_a = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66666666;
        tick(); idle(); #1;
        chk("unf_err", {31'd0, err}, 32'h1);
        chk("unf_data", rd_data_a, 32'h66666666);
        chk("unf_busy", {31'd0, busy_a}, 32'h0);
        tick();
        chk("err_sticky", {31'd0, err}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
